// File: rtl/hazard_sb.sv
// hazard_sb: hazard unit for the combined ARM/RISC-V five-stage core.
// Forwarding, load-use and control-hazard handling plus a scoreboard that
// tracks fixed-latency long-unit ops (mul/div) until their write-back.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   arm{D,E,M,W}               stage holds an ARM instruction (0 = RISC-V)
//   RegWrite{D,M,W}            stage writes a register
//   Rs1D..RdW                  register indices
//   ResultSrcE[0]              load in E
//   PCSrc{D,E,M,W}             ARM PC write in stage
//   BranchTakenE               taken branch/jump in E (either bit)
//   StallFD, FwdE              external ARM stall / forced ALUOutM forward
//   LongOpD, LongOpE           long op in D / issuing from E
//   StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE   pipeline control
//   LongWrW, LongRdW           long-unit register-file write this cycle
//   SbFull                     every scoreboard entry valid

// One scoreboard entry: loaded on alloc, counts down to retirement.
module hazard_sb_entry #(
  parameter int AW  = 5,
  parameter int LAT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alloc,
  input  logic [AW-1:0] alloc_rd,
  output logic          vld,
  output logic [AW-1:0] rd,
  output logic          retire
);
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= 1'b0;
      rd  <= '0;
      cnt <= '0;
    end else if (alloc) begin
      // Alloc wins over retire so a freed slot can be reused at the same edge.
      vld <= 1'b1;
      rd  <= alloc_rd;
      cnt <= 4'(LAT);
    end else if (vld) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) vld <= 1'b0;
    end
  end

  assign retire = vld & (cnt == 4'd1);
endmodule

module hazard_sb #(
  parameter  int NREG  = 32,
  parameter  int LAT   = 4,
  parameter  int NPEND = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          armD,
  input  logic          armE,
  input  logic          armM,
  input  logic          armW,
  input  logic          RegWriteD,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  input  logic [AW-1:0] Rs1D,
  input  logic [AW-1:0] Rs2D,
  input  logic [AW-1:0] RdD,
  input  logic [AW-1:0] Rs1E,
  input  logic [AW-1:0] Rs2E,
  input  logic [AW-1:0] RdE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic [1:0]    ResultSrcE,
  input  logic          PCSrcD,
  input  logic          PCSrcE,
  input  logic          PCSrcM,
  input  logic          PCSrcW,
  input  logic [1:0]    BranchTakenE,
  input  logic          StallFD,
  input  logic [1:0]    FwdE,
  input  logic          LongOpD,
  input  logic          LongOpE,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushD,
  output logic          FlushE,
  output logic [1:0]    ForwardAE,
  output logic [1:0]    ForwardBE,
  output logic          LongWrW,
  output logic [AW-1:0] LongRdW,
  output logic          SbFull
);
  localparam int             CW      = $clog2(NPEND + 2);
  localparam logic [CW-1:0]  NPEND_C = CW'(NPEND);

  logic                       unused;
  logic [NPEND-1:0]           vld, retire, alloc, vld_eff, retire_eff;
  logic [NPEND-1:0][AW-1:0]   ent_rd;
  logic [CW-1:0]              occ;
  logic                       found, sb_hit, sb_stall, ld_stall, pc_wr_pend;

  assign unused = ResultSrcE[1];

  // Equal indices match unless it is RISC-V x0, which is never a real dependency.
  function automatic logic rmatch(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                  input logic arm);
    return (a == b) && (arm || (a != '0));
  endfunction

  // ---------------- forwarding ----------------
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && rmatch(Rs1E, RdM, armE))      ForwardAE = 2'b10;
    else if (FwdE[0])                              ForwardAE = 2'b10;
    else if (RegWriteW && rmatch(Rs1E, RdW, armE)) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && rmatch(Rs2E, RdM, armE))      ForwardBE = 2'b10;
    else if (FwdE[1])                              ForwardBE = 2'b10;
    else if (RegWriteW && rmatch(Rs2E, RdW, armE)) ForwardBE = 2'b01;
  end

  // ---------------- scoreboard ----------------
  genvar g;
  generate
    for (g = 0; g < NPEND; g++) begin : gen_ent
      hazard_sb_entry #(.AW(AW), .LAT(LAT)) u_ent (
        .clk      (clk),
        .reset    (reset),
        .alloc    (alloc[g]),
        .alloc_rd (RdE),
        .vld      (vld[g]),
        .rd       (ent_rd[g]),
        .retire   (retire[g])
      );
    end
  endgenerate

  // The reset cycle already sees an empty scoreboard.
  assign vld_eff    = vld & {NPEND{~reset}};
  assign retire_eff = retire & {NPEND{~reset}};

  // Lowest-index slot that is free or being freed this edge.
  always_comb begin
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < NPEND; i++) begin
      if (!found && (!vld[i] || retire[i])) begin
        alloc[i] = LongOpE & ~reset;
        found    = 1'b1;
      end
    end
  end

  // Single issue at fixed latency: at most one entry retires per cycle.
  always_comb begin
    LongRdW = '0;
    for (int i = 0; i < NPEND; i++)
      if (retire_eff[i]) LongRdW = ent_rd[i];
  end
  assign LongWrW = |retire_eff;
  assign SbFull  = &vld_eff;

  always_comb begin
    occ    = '0;
    sb_hit = 1'b0;
    for (int i = 0; i < NPEND; i++) begin
      occ = occ + CW'(vld_eff[i]);
      if (vld_eff[i]) begin
        if (rmatch(Rs1D, ent_rd[i], armD) || rmatch(Rs2D, ent_rd[i], armD))
          sb_hit = 1'b1;
        if (RegWriteD && rmatch(RdD, ent_rd[i], armD))
          sb_hit = 1'b1;
      end
    end
  end

  assign sb_stall = sb_hit | (LongOpD & ((occ + CW'(LongOpE)) >= NPEND_C));

  // ---------------- pipeline control ----------------
  assign ld_stall   = ResultSrcE[0] & (rmatch(Rs1D, RdE, armD) | rmatch(Rs2D, RdE, armD));
  assign pc_wr_pend = (armD & PCSrcD) | (armE & PCSrcE) | (armM & PCSrcM);

  assign StallD = ld_stall | StallFD | sb_stall;
  assign StallF = StallD | pc_wr_pend;
  assign FlushE = ld_stall | sb_stall | (|BranchTakenE);
  assign FlushD = pc_wr_pend | (armW & PCSrcW) | (|BranchTakenE);
endmodule

// File: tb/tb_hazard_sb.sv
module tb_hazard_sb;
  localparam int NREG = 32, LAT = 4, NPEND = 2, AW = $clog2(NREG);

  logic clk = 1'b0;
  logic reset, armD, armE, armM, armW, RegWriteD, RegWriteM, RegWriteW;
  logic [AW-1:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE, BranchTakenE, FwdE;
  logic PCSrcD, PCSrcE, PCSrcM, PCSrcW, StallFD, LongOpD, LongOpE;
  logic StallF, StallD, FlushD, FlushE, LongWrW, SbFull;
  logic [1:0] ForwardAE, ForwardBE;
  logic [AW-1:0] LongRdW;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  // Reference scoreboard: destination and issue cycle of each outstanding op.
  int q_rd[$];
  int q_iss[$];

  typedef struct packed {
    logic sf, sd, fd, fe;
    logic [1:0] fa, fb;
    logic lw;
    logic [AW-1:0] lrd;
    logic full;
  } exp_t;

  always #5 clk = ~clk;

  hazard_sb #(.NREG(NREG), .LAT(LAT), .NPEND(NPEND)) dut (
    .clk(clk), .reset(reset), .armD(armD), .armE(armE), .armM(armM), .armW(armW),
    .RegWriteD(RegWriteD), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE),
    .PCSrcM(PCSrcM), .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .StallFD(StallFD),
    .FwdE(FwdE), .LongOpD(LongOpD), .LongOpE(LongOpE), .StallF(StallF), .StallD(StallD),
    .FlushD(FlushD), .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .LongWrW(LongWrW), .LongRdW(LongRdW), .SbFull(SbFull)
  );

  function automatic bit mt(int a, int b, logic arm);
    return (a == b) && (arm || a != 0);
  endfunction

  function automatic logic [1:0] mfwd(int rs, logic fe);
    if (RegWriteM && mt(rs, int'(RdM), armE)) return 2'b10;
    if (fe) return 2'b10;
    if (RegWriteW && mt(rs, int'(RdW), armE)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    int occ;
    logic ld, sb, pcw, bt;
    occ = reset ? 0 : q_rd.size();
    ld = ResultSrcE[0] && (mt(int'(Rs1D), int'(RdE), armD) || mt(int'(Rs2D), int'(RdE), armD));
    sb = 1'b0;
    e.lw = 1'b0;
    e.lrd = '0;
    if (!reset)
      foreach (q_rd[i]) begin
        if (mt(int'(Rs1D), q_rd[i], armD) || mt(int'(Rs2D), q_rd[i], armD)) sb = 1'b1;
        if (RegWriteD && mt(int'(RdD), q_rd[i], armD)) sb = 1'b1;
        if (q_iss[i] + LAT == cyc) begin e.lw = 1'b1; e.lrd = AW'(q_rd[i]); end
      end
    if (LongOpD && (occ + int'(LongOpE) >= NPEND)) sb = 1'b1;
    pcw = (armD & PCSrcD) | (armE & PCSrcE) | (armM & PCSrcM);
    bt = |BranchTakenE;
    e.sd = ld | StallFD | sb;
    e.sf = e.sd | pcw;
    e.fe = ld | sb | bt;
    e.fd = pcw | (armW & PCSrcW) | bt;
    e.fa = mfwd(int'(Rs1E), FwdE[0]);
    e.fb = mfwd(int'(Rs2E), FwdE[1]);
    e.full = (occ == NPEND);
    return e;
  endfunction

  task automatic idle();
    reset = 0; armD = 0; armE = 0; armM = 0; armW = 0;
    RegWriteD = 0; RegWriteM = 0; RegWriteW = 0;
    Rs1D = 0; Rs2D = 0; RdD = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE = 0; PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
    BranchTakenE = 0; StallFD = 0; FwdE = 0; LongOpD = 0; LongOpE = 0;
  endtask

  // Advance one clock and update the reference scoreboard from the inputs
  // that were presented during the cycle just ended.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      q_rd.delete();
      q_iss.delete();
    end else begin
      for (int i = q_rd.size() - 1; i >= 0; i--)
        if (q_iss[i] + LAT == cyc) begin q_rd.delete(i); q_iss.delete(i); end
      if (LongOpE) begin
        n_cmp++;
        if (q_rd.size() >= NPEND) begin
          n_bad++;
          $display("FAIL sb_overflow: LongOpE issued with %0d busy entries, limit %0d", q_rd.size(), NPEND);
        end
        q_rd.push_back(int'(RdE));
        q_iss.push_back(cyc);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    idle(); reset = 1;
    tick(); tick();
    #1;
    n_cmp++;
    if ({LongWrW, SbFull, StallD, StallF, FlushD, FlushE, ForwardAE, ForwardBE} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b want 0", {LongWrW, SbFull, StallD, StallF, FlushD, FlushE, ForwardAE, ForwardBE});
    end
    tick();
    idle();
    #1;
    n_cmp++;
    if ({LongWrW, SbFull, StallD} !== 3'b0) begin
      n_bad++; $display("FAIL post_reset: got %b want 000", {LongWrW, SbFull, StallD});
    end
    tick();
  endtask

  task automatic test_forward();
    idle(); RegWriteM = 1; RdM = 0; Rs1E = 0; #1;
    n_cmp++;
    if (ForwardAE !== 2'b00) begin n_bad++; $display("FAIL fwd_x0_rv: got %b want 00", ForwardAE); end
    armE = 1; #1;
    n_cmp++;
    if (ForwardAE !== 2'b10) begin n_bad++; $display("FAIL fwd_r0_arm: got %b want 10", ForwardAE); end
    idle(); RegWriteW = 1; RdW = 3; Rs2E = 3; #1;
    n_cmp++;
    if (ForwardBE !== 2'b01) begin n_bad++; $display("FAIL fwd_w: got %b want 01", ForwardBE); end
    RegWriteM = 1; RdM = 3; #1;
    n_cmp++;
    if (ForwardBE !== 2'b10) begin n_bad++; $display("FAIL fwd_m_prio: got %b want 10", ForwardBE); end
    RegWriteM = 0; FwdE = 2'b10; #1;
    n_cmp++;
    if ({ForwardAE, ForwardBE} !== 4'b0010) begin
      n_bad++; $display("FAIL fwd_forced: got %b want 0010", {ForwardAE, ForwardBE});
    end
    idle(); tick();
  endtask

  task automatic test_load_use();
    idle(); ResultSrcE = 2'b01; RdE = 5; Rs2D = 5; #1;
    n_cmp++;
    if ({StallF, StallD, FlushE} !== 3'b111) begin
      n_bad++; $display("FAIL load_use: got %b want 111", {StallF, StallD, FlushE});
    end
    tick();
    idle(); RegWriteM = 1; RdM = 5; Rs2D = 5; #1;
    n_cmp++;
    if (StallD !== 1'b0) begin n_bad++; $display("FAIL load_use_release: got %b want 0", StallD); end
    tick();
    idle(); RegWriteW = 1; RdW = 5; Rs2E = 5; #1;
    n_cmp++;
    if (ForwardBE !== 2'b01) begin n_bad++; $display("FAIL load_use_fwd: got %b want 01", ForwardBE); end
    tick();
  endtask

  task automatic test_long_raw();
    idle(); LongOpE = 1; RdE = 7; Rs1D = 7;
    tick();
    LongOpE = 0; RdE = 0;
    for (int k = 1; k <= 5; k++) begin
      #1;
      n_cmp++;
      if ({StallD, LongWrW} !== {k <= 4, k == 4} || (k == 4 && LongRdW !== AW'(7))) begin
        n_bad++;
        $display("FAIL long_raw t+%0d: StallD=%b LongWrW=%b LongRdW=%0d want %b %b 7", k, StallD, LongWrW, LongRdW, k <= 4, k == 4);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_structural();
    idle(); LongOpE = 1; RdE = 10; tick();
    RdE = 11; tick();
    LongOpE = 0; RdE = 0; LongOpD = 1; Rs1D = 20; Rs2D = 21;
    for (int k = 2; k <= 4; k++) begin
      #1;
      n_cmp++;
      if ({SbFull, StallD, LongWrW} !== {2'b11, k == 4} || (k == 4 && LongRdW !== AW'(10))) begin
        n_bad++;
        $display("FAIL struct t+%0d: SbFull=%b StallD=%b LongWrW=%b LongRdW=%0d", k, SbFull, StallD, LongWrW, LongRdW);
      end
      tick();
    end
    LongOpD = 0; LongOpE = 1; RdE = 12; #1;
    n_cmp++;
    if ({SbFull, StallD, LongWrW} !== 3'b001 || LongRdW !== AW'(11)) begin
      n_bad++;
      $display("FAIL struct t+5: SbFull=%b StallD=%b LongWrW=%b LongRdW=%0d want 0 0 1 11", SbFull, StallD, LongWrW, LongRdW);
    end
    tick();
    idle();
    for (int k = 6; k <= 9; k++) begin
      #1;
      n_cmp++;
      if (LongWrW !== (k == 9) || (k == 9 && LongRdW !== AW'(12))) begin
        n_bad++; $display("FAIL struct_realloc t+%0d: LongWrW=%b LongRdW=%0d want %b 12", k, LongWrW, LongRdW, k == 9);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    idle(); LongOpE = 1; RdE = 9; tick();
    idle(); Rs1D = 9; tick();
    reset = 1; #1;
    n_cmp++;
    if ({LongWrW, SbFull} !== 2'b00) begin
      n_bad++; $display("FAIL reset_mid: LongWrW=%b SbFull=%b want 00", LongWrW, SbFull);
    end
    tick();
    reset = 0; #1;
    n_cmp++;
    if (StallD !== 1'b0) begin n_bad++; $display("FAIL reset_mid_stall: got %b want 0", StallD); end
    for (int k = 3; k <= 7; k++) begin
      #1;
      n_cmp++;
      if (LongWrW !== 1'b0) begin n_bad++; $display("FAIL reset_mid_wb t+%0d: got %b want 0", k, LongWrW); end
      tick();
    end
    idle();
  endtask

  task automatic test_branch();
    idle(); LongOpE = 1; RdE = 13; armE = 1; PCSrcE = 1; BranchTakenE = 2'b01; #1;
    n_cmp++;
    if ({StallF, FlushD, FlushE, StallD} !== 4'b1110) begin
      n_bad++; $display("FAIL branch: StallF/FlushD/FlushE/StallD=%b want 1110", {StallF, FlushD, FlushE, StallD});
    end
    tick();
    idle(); armW = 1; PCSrcW = 1; PCSrcD = 1; #1;
    n_cmp++;
    if ({FlushD, StallF} !== 2'b10) begin
      n_bad++; $display("FAIL flush_w: FlushD/StallF=%b want 10", {FlushD, StallF});
    end
    tick();
    idle();
    for (int k = 2; k <= 5; k++) begin
      #1;
      n_cmp++;
      if (LongWrW !== (k == 4) || (k == 4 && LongRdW !== AW'(13))) begin
        n_bad++; $display("FAIL branch_sb t+%0d: LongWrW=%b LongRdW=%0d want %b 13", k, LongWrW, LongRdW, k == 4);
      end
      tick();
    end
  endtask

  task automatic test_random();
    exp_t e;
    int busy;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      armD = 1'($urandom); armE = 1'($urandom); armM = 1'($urandom); armW = 1'($urandom);
      RegWriteD = 1'($urandom); RegWriteM = 1'($urandom); RegWriteW = 1'($urandom);
      Rs1D = AW'($urandom_range(0, 7)); Rs2D = AW'($urandom_range(0, 7)); RdD = AW'($urandom_range(0, 7));
      Rs1E = AW'($urandom_range(0, 7)); Rs2E = AW'($urandom_range(0, 7)); RdE = AW'($urandom_range(0, 7));
      RdM = AW'($urandom_range(0, 7)); RdW = AW'($urandom_range(0, 7));
      ResultSrcE = 2'($urandom_range(0, 3) & ($urandom_range(0, 3) == 0 ? 3 : 2));
      PCSrcD = ($urandom_range(0, 7) == 0); PCSrcE = ($urandom_range(0, 7) == 0);
      PCSrcM = ($urandom_range(0, 7) == 0); PCSrcW = ($urandom_range(0, 7) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      StallFD = ($urandom_range(0, 15) == 0);
      FwdE = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
      LongOpD = 1'($urandom);
      // Issue only when the reference says a slot is free or being freed.
      busy = 0;
      foreach (q_iss[i]) if (q_iss[i] + LAT != cyc) busy++;
      LongOpE = !reset && (busy < NPEND) && ($urandom_range(0, 2) == 0);
      #1;
      e = model_eval();
      n_cmp++;
      if ({StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, LongWrW, (LongWrW ? LongRdW : AW'(0)), SbFull}
          !== {e.sf, e.sd, e.fd, e.fe, e.fa, e.fb, e.lw, e.lrd, e.full}) begin
        n_bad++;
        $display("FAIL random cyc %0d: got SF%b SD%b FD%b FE%b FA%b FB%b LW%b LRD%0d FULL%b want SF%b SD%b FD%b FE%b FA%b FB%b LW%b LRD%0d FULL%b",
                 cyc, StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE, LongWrW, LongRdW, SbFull,
                 e.sf, e.sd, e.fd, e.fe, e.fa, e.fb, e.lw, e.lrd, e.full);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_forward();
    test_load_use();
    test_long_raw();
    test_structural();
    test_reset_mid();
    test_branch();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
